// File: rtl/tilt_pkg.sv
// -----------------------------------------------------------------------------
// tilt_pkg
// Shared constants, the per-axis tilt state type and the state transition
// function used by tilt_axis.
// -----------------------------------------------------------------------------
package tilt_pkg;

  // Accelerometer reading for a level board.
  localparam logic [8:0] CENTER = 9'h100;

  // Boxcar filter depth and its log2. The average is sum >> HIST_LOG2.
  localparam int unsigned HIST_DEPTH = 8;
  localparam int unsigned HIST_LOG2  = 3;

  // Running-sum width: 8 * 511 = 4088 fits in 12 bits with no overflow.
  localparam int unsigned     SUM_W     = 12;
  localparam logic [SUM_W-1:0] SUM_RESET = 12'h800;  // HIST_DEPTH * CENTER

  typedef enum logic [1:0] {
    NEUTRAL = 2'd0,
    POS     = 2'd1,
    NEG     = 2'd2
  } axis_state_e;

  // Hysteretic next-state rule for one axis. A strong opposite tilt jumps
  // straight across without passing through NEUTRAL; leaving a tilted state
  // otherwise needs the offset to fall inside the narrower exit band.
  function automatic axis_state_e axis_next_state(
    input axis_state_e        cur,
    input logic signed [9:0]  off,
    input logic signed [9:0]  enter_th,
    input logic signed [9:0]  exit_th
  );
    axis_state_e nxt;
    nxt = cur;
    case (cur)
      NEUTRAL: begin
        if (off >= enter_th)       nxt = POS;
        else if (off <= -enter_th) nxt = NEG;
      end
      POS: begin
        if (off <= -enter_th)      nxt = NEG;
        else if (off < exit_th)    nxt = NEUTRAL;
      end
      NEG: begin
        if (off >= enter_th)       nxt = POS;
        else if (off > -exit_th)   nxt = NEUTRAL;
      end
      default:                     nxt = NEUTRAL;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/tilt_axis.sv
// -----------------------------------------------------------------------------
// tilt_axis
// One accelerometer axis: 8-entry sample history, running sum, truncated
// boxcar average and the NEUTRAL/POS/NEG hysteresis FSM.
//
// Ports
//   clk        system clock
//   reset      synchronous active-high reset
//   tick_i     sample strobe: capture accel_i and update the running sum
//   upd_i      one cycle after tick_i: register the average and FSM state
//   accel_i    raw 9-bit axis reading, centre 9'h100
//   filt_o     registered boxcar average (changes only on upd_i)
//   state_d_o  next FSM state, valid while upd_i is high; the parent
//              registers its output decode from this in the same edge
// -----------------------------------------------------------------------------
module tilt_axis
  import tilt_pkg::*;
#(
  parameter int unsigned ENTER_TH = 40,
  parameter int unsigned EXIT_TH  = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_i,
  input  logic        upd_i,
  input  logic [8:0]  accel_i,
  output logic [8:0]  filt_o,
  output axis_state_e state_d_o
);

  localparam logic signed [9:0] ENTER_S  = 10'(ENTER_TH);
  localparam logic signed [9:0] EXIT_S   = 10'(EXIT_TH);
  localparam logic signed [9:0] CENTER_S = 10'sd256;

  logic [8:0]           hist_q [HIST_DEPTH];
  logic [HIST_LOG2-1:0] wr_ptr_q;
  logic [SUM_W-1:0]     sum_q;
  logic [SUM_W-1:0]     sum_d;
  logic [8:0]           filt_q;
  axis_state_e          state_q;
  axis_state_e          state_d;

  logic [8:0]           avg;
  logic signed [9:0]    offset;

  // The slot about to be overwritten holds the oldest sample, so the sum can
  // be maintained incrementally. Wrap-around arithmetic is exact here since
  // the true result always lies in 0..4088.
  assign sum_d  = sum_q + {3'b000, accel_i} - {3'b000, hist_q[wr_ptr_q]};

  assign avg    = sum_q[SUM_W-1:HIST_LOG2];
  assign offset = signed'({1'b0, avg}) - CENTER_S;

  always_comb begin
    state_d = axis_next_state(state_q, offset, ENTER_S, EXIT_S);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < HIST_DEPTH; i++) begin
        hist_q[i] <= CENTER;
      end
      wr_ptr_q <= '0;
      sum_q    <= SUM_RESET;
      filt_q   <= CENTER;
      state_q  <= NEUTRAL;
    end else begin
      if (tick_i) begin
        hist_q[wr_ptr_q] <= accel_i;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
        sum_q            <= sum_d;
      end
      if (upd_i) begin
        filt_q  <= avg;
        state_q <= state_d;
      end
    end
  end

  assign filt_o    = filt_q;
  assign state_d_o = state_d;

endmodule

// File: rtl/tilt_control.sv
// -----------------------------------------------------------------------------
// tilt_control
// Samples a 2-axis accelerometer at a fixed rate, boxcar-filters each axis
// and turns the filtered tilt into rotate/thrust control levels.
//
// Pipeline per sample: tick cycle (count == SAMPLE_DIV-1) -> sums update ->
// averages, FSM states and control outputs register with sample_valid high.
//
// Ports
//   clk           system clock
//   reset         synchronous active-high reset
//   accelX        raw front/back tilt, centre 9'h100
//   accelY        raw left/right tilt, centre 9'h100
//   filt_x        8-sample average of accelX
//   filt_y        8-sample average of accelY
//   sample_valid  one-cycle pulse when filt_* and controls update
//   rot_left      Y axis tilted negative
//   rot_right     Y axis tilted positive
//   thrust        X axis tilted positive (X negative is unused)
// -----------------------------------------------------------------------------
module tilt_control
  import tilt_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = 100000,
  parameter int unsigned ENTER_TH   = 40,
  parameter int unsigned EXIT_TH    = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] accelX,
  input  logic [8:0] accelY,
  output logic [8:0] filt_x,
  output logic [8:0] filt_y,
  output logic       sample_valid,
  output logic       rot_left,
  output logic       rot_right,
  output logic       thrust
);

  localparam int unsigned      CNT_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             tick;
  logic             upd_q;
  logic             sample_valid_q;
  logic             rot_left_q;
  logic             rot_right_q;
  logic             thrust_q;

  axis_state_e      x_state_d;
  axis_state_e      y_state_d;

  assign tick = (cnt_q == CNT_LAST);

  tilt_axis #(
    .ENTER_TH (ENTER_TH),
    .EXIT_TH  (EXIT_TH)
  ) u_axis_x (
    .clk       (clk),
    .reset     (reset),
    .tick_i    (tick),
    .upd_i     (upd_q),
    .accel_i   (accelX),
    .filt_o    (filt_x),
    .state_d_o (x_state_d)
  );

  tilt_axis #(
    .ENTER_TH (ENTER_TH),
    .EXIT_TH  (EXIT_TH)
  ) u_axis_y (
    .clk       (clk),
    .reset     (reset),
    .tick_i    (tick),
    .upd_i     (upd_q),
    .accel_i   (accelY),
    .filt_o    (filt_y),
    .state_d_o (y_state_d)
  );

  // Control levels are decoded from the next state in the same edge that the
  // axis registers it, so they line up with filt_* and sample_valid. A single
  // enum value per axis keeps rot_left/rot_right mutually exclusive.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q          <= '0;
      upd_q          <= 1'b0;
      sample_valid_q <= 1'b0;
      rot_left_q     <= 1'b0;
      rot_right_q    <= 1'b0;
      thrust_q       <= 1'b0;
    end else begin
      cnt_q          <= tick ? '0 : cnt_q + 1'b1;
      upd_q          <= tick;
      sample_valid_q <= upd_q;
      if (upd_q) begin
        rot_left_q  <= (y_state_d == NEG);
        rot_right_q <= (y_state_d == POS);
        thrust_q    <= (x_state_d == POS);
      end
    end
  end

  assign sample_valid = sample_valid_q;
  assign rot_left     = rot_left_q;
  assign rot_right    = rot_right_q;
  assign thrust       = thrust_q;

endmodule

// File: tb/tb_tilt_control.sv
// -----------------------------------------------------------------------------
// tb_tilt_control
// Directed bench for tilt_control with SAMPLE_DIV=4, ENTER_TH=40, EXIT_TH=24.
// Expected filter values are hand-computed truncated 8-sample averages.
// -----------------------------------------------------------------------------
module tb_tilt_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] accelX;
  logic [8:0] accelY;
  logic [8:0] filt_x;
  logic [8:0] filt_y;
  logic       sample_valid;
  logic       rot_left;
  logic       rot_right;
  logic       thrust;

  int total = 0;
  int bad   = 0;

  tilt_control #(
    .SAMPLE_DIV (4),
    .ENTER_TH   (40),
    .EXIT_TH    (24)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .accelX       (accelX),
    .accelY       (accelY),
    .filt_x       (filt_x),
    .filt_y       (filt_y),
    .sample_valid (sample_valid),
    .rot_left     (rot_left),
    .rot_right    (rot_right),
    .thrust       (thrust)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance until sample_valid is seen; n is the number of cycles taken,
  // capped at 20 so a missing pulse shows up as a wrong count.
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (sample_valid !== 1'b1 && n < 20);
  endtask

  task automatic sample_chk(input string tag, input int fx, input int fy,
                            input bit rl, input bit rr, input bit th);
    check({tag, "_valid"}, 32'(sample_valid), 32'd1);
    check({tag, "_filt_x"}, 32'(filt_x), 32'(fx));
    check({tag, "_filt_y"}, 32'(filt_y), 32'(fy));
    check({tag, "_rot_left"}, 32'(rot_left), 32'(rl));
    check({tag, "_rot_right"}, 32'(rot_right), 32'(rr));
    check({tag, "_thrust"}, 32'(thrust), 32'(th));
    check({tag, "_excl"}, 32'(rot_left & rot_right), 32'd0);
  endtask

  task automatic reset_chk(input string tag);
    check({tag, "_filt_x"}, 32'(filt_x), 32'd256);
    check({tag, "_filt_y"}, 32'(filt_y), 32'd256);
    check({tag, "_valid"}, 32'(sample_valid), 32'd0);
    check({tag, "_rot_left"}, 32'(rot_left), 32'd0);
    check({tag, "_rot_right"}, 32'(rot_right), 32'd0);
    check({tag, "_thrust"}, 32'(thrust), 32'd0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int up_avg [8];
    int dn_avg [8];
    up_avg = '{301, 331, 361, 391, 421, 451, 481, 511};
    dn_avg = '{447, 383, 319, 255, 191, 127, 63, 0};

    // Reset and idle at centre.
    reset  = 1'b1;
    accelX = 9'h100;
    accelY = 9'h100;
    repeat (3) step();
    reset_chk("in_reset");
    reset = 1'b0;

    wait_valid(n);
    check("first_latency", 32'(n), 32'd5);
    sample_chk("idle0", 256, 256, 0, 0, 0);
    for (int i = 1; i < 16; i++) begin
      wait_valid(n);
      check($sformatf("idle%0d_period", i), 32'(n), 32'd4);
      sample_chk($sformatf("idle%0d", i), 256, 256, 0, 0, 0);
    end

    // Y step to 9'h140: average climbs by 8 per sample, enters POS at offset 40.
    accelY = 9'h140;
    for (int k = 1; k <= 8; k++) begin
      wait_valid(n);
      check($sformatf("ramp%0d_period", k), 32'(n), 32'd4);
      sample_chk($sformatf("ramp%0d", k), 256, 256 + 8 * k, 0, (k >= 5), 0);
    end

    // Y step to 9'h110: average falls by 6; POS held down to offset 28, left at 22.
    accelY = 9'h110;
    for (int k = 1; k <= 8; k++) begin
      wait_valid(n);
      sample_chk($sformatf("fall%0d", k), 256, 320 - 6 * k, 0, (k <= 6), 0);
    end

    // Full-scale positive, then full-scale negative.
    accelY = 9'h1FF;
    for (int k = 0; k < 8; k++) begin
      wait_valid(n);
      sample_chk($sformatf("max%0d", k), 256, up_avg[k], 0, 1, 0);
    end
    accelY = 9'h000;
    for (int k = 0; k < 8; k++) begin
      wait_valid(n);
      sample_chk($sformatf("min%0d", k), 256, dn_avg[k], (k >= 4), (k <= 2), 0);
    end

    // One-cycle X glitch landing on a non-tick cycle must be ignored.
    step();
    accelX = 9'h1C0;
    step();
    accelX = 9'h100;
    wait_valid(n);
    sample_chk("glitch0", 256, 0, 1, 0, 0);
    wait_valid(n);
    check("glitch1_period", 32'(n), 32'd4);
    sample_chk("glitch1", 256, 0, 1, 0, 0);

    // X held at 9'h1C0: +24 per sample, thrust from offset 48.
    accelX = 9'h1C0;
    for (int k = 1; k <= 3; k++) begin
      wait_valid(n);
      sample_chk($sformatf("thrust%0d", k), 256 + 24 * k, 0, 1, 0, (k >= 2));
    end

    // One-cycle reset during the tick cycle.
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    reset_chk("mid_reset");
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("post_reset_quiet%0d", i), 32'(sample_valid), 32'd0);
    end
    step();
    sample_chk("post_reset", 280, 224, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
